// File: rtl/noc_flit_packetizer.sv
// Splits user messages into head/body/tail NoC flits and gates injection on per-VC credits.
// Optional statistics outputs are enabled by defining NOC_PKT_STATS_EN.
module noc_flit_packetizer #(
    parameter int WIDTH          = 128,
    parameter int N              = 16,
    parameter int NUM_VC         = 2,
    parameter int MAX_FLITS      = 4,
    parameter int CREDITS_PER_VC = 8,
    localparam int ADDRESS_WIDTH    = $clog2(N),
    localparam int VC_ADDRESS_WIDTH = $clog2(NUM_VC),
    localparam int DATA_W           = WIDTH - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH,
    localparam int LEN_W            = $clog2(MAX_FLITS + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_msg_valid,
    output logic                          o_msg_ready,
    input  logic [MAX_FLITS*DATA_W-1:0]   i_msg_data,
    input  logic [LEN_W-1:0]              i_msg_len,
    input  logic [ADDRESS_WIDTH-1:0]      i_msg_dest,
    input  logic [VC_ADDRESS_WIDTH-1:0]   i_msg_vc,
    output logic [WIDTH-1:0]              o_flit_out,
    input  logic [NUM_VC-1:0]             i_credits,
`ifdef NOC_PKT_STATS_EN
    output logic [31:0]                   o_pkt_count,
    output logic [31:0]                   o_stall_count,
`endif
    output logic                          o_busy
);

    localparam int CNT_W = $clog2(CREDITS_PER_VC + 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

    state_e                        state_q, state_d;
    logic                          started_q;
    logic [MAX_FLITS*DATA_W-1:0]   data_q, data_d;
    logic [LEN_W-1:0]              len_q, len_d, k_q, k_d, len_in;
    logic [ADDRESS_WIDTH-1:0]      dest_q, dest_d;
    logic [VC_ADDRESS_WIDTH-1:0]   vc_q, vc_d;
    logic [WIDTH-1:0]              flit_q, flit_d;
    logic [CNT_W-1:0]              cnt_q [NUM_VC];
    logic [CNT_W-1:0]              cnt_d [NUM_VC];
    logic [CNT_W:0]                cnt_sum [NUM_VC];
    logic [DATA_W-1:0]             slice;
    logic                          has_credit, is_last, issue, accept, msg_ready, busy;

    // Handshake: a message transfers on any rising edge where i_msg_valid and o_msg_ready are
    // both high; ready is also raised while the tail flit issues so packets chain without a gap.
    assign has_credit = (cnt_q[vc_q] != '0);
    assign is_last    = (k_q == len_q - LEN_W'(1));
    assign accept     = i_msg_valid & msg_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: if (issue && is_last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        msg_ready = 1'b0;
        busy      = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: msg_ready = started_q;
            SEND: begin
                busy      = 1'b1;
                issue     = has_credit;
                msg_ready = has_credit && is_last;
            end
            default: ;
        endcase
    end

    always_comb begin
        len_in = i_msg_len;
        if (i_msg_len == '0) begin
            len_in = LEN_W'(1);
        end else if (i_msg_len > LEN_W'(MAX_FLITS)) begin
            len_in = LEN_W'(MAX_FLITS);
        end
    end

    always_comb begin
        slice = '0;
        for (int i = 0; i < MAX_FLITS; i++) begin
            if (k_q == LEN_W'(i)) slice = data_q[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        dest_d = dest_q;
        vc_d   = vc_q;
        k_d    = k_q;
        if (accept) begin
            data_d = i_msg_data;
            len_d  = len_in;
            dest_d = i_msg_dest;
            vc_d   = i_msg_vc;
            k_d    = '0;
        end else if (issue) begin
            k_d = k_q + LEN_W'(1);
        end
        flit_d = issue ? {1'b1, (k_q == '0), is_last, vc_q, dest_q, slice} : '0;
    end

    // Return and use are summed before the clamp so a simultaneous pair at full count is a no-op.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            cnt_sum[v] = {1'b0, cnt_q[v]} + (CNT_W+1)'(i_credits[v])
                       - (CNT_W+1)'(issue && (vc_q == VC_ADDRESS_WIDTH'(v)));
            cnt_d[v]   = (cnt_sum[v] > (CNT_W+1)'(CREDITS_PER_VC)) ?
                         CNT_W'(CREDITS_PER_VC) : cnt_sum[v][CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q <= 1'b0;
            data_q    <= '0;
            len_q     <= '0;
            dest_q    <= '0;
            vc_q      <= '0;
            k_q       <= '0;
            flit_q    <= '0;
            for (int v = 0; v < NUM_VC; v++) cnt_q[v] <= CNT_W'(CREDITS_PER_VC);
        end else begin
            started_q <= 1'b1;
            data_q    <= data_d;
            len_q     <= len_d;
            dest_q    <= dest_d;
            vc_q      <= vc_d;
            k_q       <= k_d;
            flit_q    <= flit_d;
            for (int v = 0; v < NUM_VC; v++) cnt_q[v] <= cnt_d[v];
        end
    end

`ifdef NOC_PKT_STATS_EN
    logic [31:0] pkt_q, stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_q   <= '0;
            stall_q <= '0;
        end else begin
            if (issue && is_last)               pkt_q   <= pkt_q + 32'd1;
            if (state_q == SEND && !has_credit) stall_q <= stall_q + 32'd1;
        end
    end

    assign o_pkt_count   = pkt_q;
    assign o_stall_count = stall_q;
`endif

    assign o_flit_out  = flit_q;
    assign o_msg_ready = msg_ready;
    assign o_busy      = busy;

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Randomized bench for noc_flit_packetizer against a queue-based packet/credit reference model.
module tb_noc_flit_packetizer;

    localparam int WIDTH          = 128;
    localparam int N              = 16;
    localparam int NUM_VC         = 2;
    localparam int MAX_FLITS      = 4;
    localparam int CREDITS_PER_VC = 8;
    localparam int AW             = $clog2(N);
    localparam int VW             = $clog2(NUM_VC);
    localparam int DATA_W         = WIDTH - 3 - VW - AW;
    localparam int LEN_W          = $clog2(MAX_FLITS + 1);

    logic                        clk;
    logic                        reset_n;
    logic                        msg_valid;
    logic                        msg_ready;
    logic [MAX_FLITS*DATA_W-1:0] msg_data;
    logic [LEN_W-1:0]            msg_len;
    logic [AW-1:0]               msg_dest;
    logic [VW-1:0]               msg_vc;
    logic [WIDTH-1:0]            flit_out;
    logic [NUM_VC-1:0]           cred_in;
    logic                        busy;
`ifdef NOC_PKT_STATS_EN
    logic [31:0]                 pkt_count;
    logic [31:0]                 stall_count;
`endif

    noc_flit_packetizer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_msg_valid (msg_valid),
        .o_msg_ready (msg_ready),
        .i_msg_data  (msg_data),
        .i_msg_len   (msg_len),
        .i_msg_dest  (msg_dest),
        .i_msg_vc    (msg_vc),
        .o_flit_out  (flit_out),
        .i_credits   (cred_in),
`ifdef NOC_PKT_STATS_EN
        .o_pkt_count   (pkt_count),
        .o_stall_count (stall_count),
`endif
        .o_busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard and reference model state
    logic [WIDTH-1:0] exp_q[$];
    int               mcred [NUM_VC];
    int               cur_vc;
    bit               started;
    bit               last_accept;
    int               exp_pkt;
    int               exp_stall;
    int               n_tests;
    int               n_fail;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_stats();
`ifdef NOC_PKT_STATS_EN
        check_val("pkt_count", WIDTH'(pkt_count), WIDTH'(32'(exp_pkt)));
        check_val("stall_count", WIDTH'(stall_count), WIDTH'(32'(exp_stall)));
`endif
    endtask

    // One clock: predict ready, issue and credits from the model, then compare after the edge.
    task automatic step();
        logic             rdy_exp;
        logic             iss;
        logic [WIDTH-1:0] exp_flit;
        int               len;
        int               c;
        rdy_exp = started && (exp_q.size() == 0 ||
                              (exp_q.size() == 1 && mcred[cur_vc] > 0));
        check_val("msg_ready", WIDTH'(msg_ready), WIDTH'(rdy_exp));
        last_accept = msg_valid && rdy_exp;
        iss = (exp_q.size() > 0) && (mcred[cur_vc] > 0);
        exp_flit = '0;
        if (iss) begin
            exp_flit = exp_q.pop_front();
            if (exp_flit[WIDTH-3]) exp_pkt++;
        end else if (exp_q.size() > 0) begin
            exp_stall++;
        end
        for (int v = 0; v < NUM_VC; v++) begin
            c = mcred[v] + int'(cred_in[v]) - ((iss && cur_vc == v) ? 1 : 0);
            if (c > CREDITS_PER_VC) c = CREDITS_PER_VC;
            mcred[v] = c;
        end
        if (last_accept) begin
            len = int'(msg_len);
            if (len == 0) len = 1;
            if (len > MAX_FLITS) len = MAX_FLITS;
            cur_vc = int'(msg_vc);
            for (int k = 0; k < len; k++) begin
                exp_q.push_back({1'b1, (k == 0), (k == len - 1), msg_vc, msg_dest,
                                 msg_data[k*DATA_W +: DATA_W]});
            end
        end
        started = 1'b1;
        @(posedge clk);
        #1;
        check_val("flit_out", flit_out, exp_flit);
        check_val("busy", WIDTH'(busy), WIDTH'(exp_q.size() > 0));
        check_stats();
    endtask

    // driver tasks
    task automatic idle(input int n);
        msg_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_data();
        for (int i = 0; i < (MAX_FLITS*DATA_W)/32; i++) msg_data[i*32 +: 32] = $urandom();
    endtask

    task automatic send_msg(input int len, input int dest, input int vc);
        bit done;
        done      = 1'b0;
        msg_valid = 1'b1;
        msg_len   = LEN_W'(len);
        msg_dest  = AW'(dest);
        msg_vc    = VW'(vc);
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            done = last_accept;
        end
        if (!done) check_val("accept_timeout", WIDTH'(done), WIDTH'(1));
    endtask

    task automatic apply_reset(input bit mid_run);
        reset_n   = 1'b0;
        msg_valid = 1'b0;
        cred_in   = '0;
        exp_q.delete();
        for (int v = 0; v < NUM_VC; v++) mcred[v] = CREDITS_PER_VC;
        started   = 1'b0;
        cur_vc    = 0;
        exp_pkt   = 0;
        exp_stall = 0;
        if (mid_run) begin
            #1;
            check_val("rst_async_flit", flit_out, '0);
            check_val("rst_async_busy", WIDTH'(busy), '0);
            check_val("rst_async_ready", WIDTH'(msg_ready), '0);
            check_stats();
        end
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_flit", flit_out, '0);
        check_val("rst_busy", WIDTH'(busy), '0);
        check_val("rst_ready", WIDTH'(msg_ready), '0);
        check_stats();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic random_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (!msg_valid || last_accept) begin
                msg_valid = ($urandom_range(0, 2) != 0);
                msg_len   = LEN_W'($urandom_range(0, 7));
                msg_dest  = AW'($urandom_range(0, N - 1));
                msg_vc    = VW'($urandom_range(0, NUM_VC - 1));
                rand_data();
            end
            for (int v = 0; v < NUM_VC; v++) cred_in[v] = ($urandom_range(0, 3) == 0);
            step();
        end
        msg_valid = 1'b0;
        cred_in   = '0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        last_accept = 1'b0;
        msg_data    = '0;
        msg_len     = '0;
        msg_dest    = '0;
        msg_vc      = '0;
        apply_reset(1'b0);

        // single-flit packet, head=tail, vc1 dest15 data A5
        idle(1);
        msg_data       = '0;
        msg_data[7:0]  = 8'hA5;
        send_msg(1, 15, 1);
        idle(3);

        // len=4 on vc0 with full credits
        rand_data();
        send_msg(4, $urandom_range(0, N - 1), 0);
        idle(6);

        // refill past the limit, then issue with a credit returned every cycle
        cred_in = 2'b01;
        idle(6);
        rand_data();
        send_msg(4, $urandom_range(0, N - 1), 0);
        idle(5);
        cred_in = '0;

        // nine single-flit messages on vc0 with no return: ninth stalls until one credit
        for (int i = 0; i < 9; i++) begin
            rand_data();
            send_msg(1, $urandom_range(0, N - 1), 0);
        end
        idle(4);
        cred_in = 2'b01;
        step();
        cred_in = '0;
        idle(3);

        // two back-to-back len=2 packets with valid held high
        cred_in = 2'b11;
        idle(10);
        cred_in = '0;
        rand_data();
        send_msg(2, 3, 1);
        rand_data();
        send_msg(2, 9, 1);
        idle(5);

        random_phase(400);

        // reset asserted after the second flit of a len=4 packet
        cred_in = 2'b11;
        idle(10);
        cred_in = '0;
        rand_data();
        send_msg(4, 5, 0);
        msg_valid = 1'b0;
        step();
        step();
        apply_reset(1'b1);

        random_phase(150);
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
